// File: rtl/gpio_func_switch_pkg.sv
// Shared constants and helpers for the GPIO function switch.
// State encoding and guard counter sizing.
package gpio_func_switch_pkg;

    localparam logic ST_ACTIVE = 1'b0;
    localparam logic ST_DRAIN  = 1'b1;

    // Ceiling log2 usable in parameter context.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Width needed to hold 0..guard inclusive, at least one bit.
    function automatic int cnt_width(input int guard);
        int w;
        w = clog2(guard + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/gpio_pin_switch.sv
// One pin of the GPIO function switch: ACTIVE/DRAIN FSM,
// guard counter, current/pending select and output registers.
module gpio_pin_switch
    import gpio_func_switch_pkg::*;
#(
    parameter int NUM_FUNC     = 4,
    parameter int SEL_W        = 2,
    parameter int GUARD_CYCLES = 4
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [NUM_FUNC-1:0] func_out,
    input  logic [NUM_FUNC-1:0] func_oe,
    input  logic [SEL_W-1:0]    sel_req,
    input  logic                sel_wr,
    output logic                gpio_out,
    output logic                gpio_oe,
    output logic                busy,
    output logic                sel_bad
);

    localparam int CW = cnt_width(GUARD_CYCLES);
    localparam logic [CW-1:0] CNT_LOAD = CW'(GUARD_CYCLES - 1);
    localparam logic [SEL_W:0] NF = (SEL_W + 1)'(NUM_FUNC);

    logic             state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [SEL_W-1:0] cur_q, cur_d;
    logic [SEL_W-1:0] pend_q, pend_d;
    logic             out_q, out_d;
    logic             oe_q, oe_d;

    logic req_ok;
    logic start;
    logic retarget;
    logic done;

    function automatic logic pick(
        input logic [NUM_FUNC-1:0] v,
        input logic [SEL_W-1:0]    s
    );
        logic b;
        b = 1'b0;
        for (int f = 0; f < NUM_FUNC; f++) begin
            if (s == SEL_W'(f)) b = v[f];
        end
        return b;
    endfunction

    // Classify this cycle's select write against the pin state.
    always_comb begin
        req_ok   = ({1'b0, sel_req} < NF);
        start    = sel_wr && req_ok && (state_q == ST_ACTIVE)
                   && (sel_req != cur_q);
        retarget = sel_wr && req_ok && (state_q == ST_DRAIN)
                   && (sel_req != pend_q);
        done     = (state_q == ST_DRAIN) && !retarget
                   && (cnt_q == '0);
    end

    // Next state, guard counter and select bookkeeping.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cur_d   = cur_q;
        pend_d  = pend_q;
        if (start || retarget) begin
            state_d = ST_DRAIN;
            cnt_d   = CNT_LOAD;
            pend_d  = sel_req;
        end else if (done) begin
            state_d = ST_ACTIVE;
            cur_d   = pend_q;
        end else if (state_q == ST_DRAIN) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Pad drive: tri-state while draining, data held.
    always_comb begin
        out_d = out_q;
        oe_d  = oe_q;
        if (done) begin
            out_d = pick(func_out, pend_q);
            oe_d  = pick(func_oe, pend_q);
        end else if ((state_q == ST_DRAIN) || start) begin
            oe_d = 1'b0;
        end else begin
            out_d = pick(func_out, cur_q);
            oe_d  = pick(func_oe, cur_q);
        end
    end

    // Pin state and output registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_ACTIVE;
            cnt_q   <= '0;
            cur_q   <= '0;
            pend_q  <= '0;
            out_q   <= 1'b0;
            oe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cur_q   <= cur_d;
            pend_q  <= pend_d;
            out_q   <= out_d;
            oe_q    <= oe_d;
        end
    end

    assign gpio_out = out_q;
    assign gpio_oe  = oe_q;
    assign busy     = (state_q == ST_DRAIN);
    assign sel_bad  = sel_wr && !req_ok;

endmodule

// File: rtl/gpio_func_switch.sv
// N-way per-pin GPIO function mux with guarded switchover.
// GPIO_FUNC_SWITCH_SYNC_EN adds a 2-flop input synchronizer.
module gpio_func_switch
    import gpio_func_switch_pkg::*;
#(
    parameter int GPIO_WIDTH   = 16,
    parameter int NUM_FUNC     = 4,
    parameter int SEL_W        = 2,
    parameter int GUARD_CYCLES = 4
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic [GPIO_WIDTH*NUM_FUNC-1:0] func_out,
    input  logic [GPIO_WIDTH*NUM_FUNC-1:0] func_oe,
    input  logic [GPIO_WIDTH*SEL_W-1:0]    sel,
    input  logic                           sel_wr,
    input  logic [GPIO_WIDTH-1:0]          gpio_in,
    output logic [GPIO_WIDTH-1:0]          gpio_out,
    output logic [GPIO_WIDTH-1:0]          gpio_oe,
    output logic [GPIO_WIDTH-1:0]          gpio_in_func,
    output logic [GPIO_WIDTH-1:0]          busy,
    output logic                           sel_err
);

    logic [GPIO_WIDTH-1:0] bad;
    logic                  sel_err_q, sel_err_d;

    for (genvar i = 0; i < GPIO_WIDTH; i++) begin : g_pin
        logic [NUM_FUNC-1:0] fo;
        logic [NUM_FUNC-1:0] foe;

        for (genvar f = 0; f < NUM_FUNC; f++) begin : g_f
            assign fo[f]  = func_out[f*GPIO_WIDTH+i];
            assign foe[f] = func_oe[f*GPIO_WIDTH+i];
        end

        gpio_pin_switch #(
            .NUM_FUNC     (NUM_FUNC),
            .SEL_W        (SEL_W),
            .GUARD_CYCLES (GUARD_CYCLES)
        ) u_pin (
            .clk      (clk),
            .resetn   (resetn),
            .func_out (fo),
            .func_oe  (foe),
            .sel_req  (sel[i*SEL_W +: SEL_W]),
            .sel_wr   (sel_wr),
            .gpio_out (gpio_out[i]),
            .gpio_oe  (gpio_oe[i]),
            .busy     (busy[i]),
            .sel_bad  (bad[i])
        );
    end

    // Any pin rejecting its select latches the error.
    always_comb begin
        sel_err_d = sel_err_q | (|bad);
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) sel_err_q <= 1'b0;
        else         sel_err_q <= sel_err_d;
    end

    assign sel_err = sel_err_q;

`ifdef GPIO_FUNC_SWITCH_SYNC_EN
    logic [GPIO_WIDTH-1:0] sync1_q, sync1_d;
    logic [GPIO_WIDTH-1:0] sync2_q, sync2_d;

    // Two-stage shift of the raw pad inputs.
    always_comb begin
        sync1_d = gpio_in;
        sync2_d = sync1_q;
    end

    // Synchronizer flops.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign gpio_in_func = sync2_q;
`else
    assign gpio_in_func = gpio_in;
`endif

endmodule

// File: tb/tb_gpio_func_switch.sv
// Directed bench for gpio_func_switch with a cycle-timestamp
// reference model and hand-computed spot checks.
module tb_gpio_func_switch;

    localparam int W  = 16;
    localparam int NF = 4;
    localparam int SW = 3;
    localparam int G  = 4;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic [W*NF-1:0]   func_out;
    logic [W*NF-1:0]   func_oe;
    logic [W*SW-1:0]   sel = '0;
    logic              sel_wr = 1'b0;
    logic [W-1:0]      gpio_in = '0;
    logic [W-1:0]      gpio_out;
    logic [W-1:0]      gpio_oe;
    logic [W-1:0]      gpio_in_func;
    logic [W-1:0]      busy;
    logic              sel_err;

    int n_vec = 0;
    int n_miss = 0;

    gpio_func_switch #(
        .GPIO_WIDTH   (W),
        .NUM_FUNC     (NF),
        .SEL_W        (SW),
        .GUARD_CYCLES (G)
    ) u_dut (
        .clk          (clk),
        .resetn       (resetn),
        .func_out     (func_out),
        .func_oe      (func_oe),
        .sel          (sel),
        .sel_wr       (sel_wr),
        .gpio_in      (gpio_in),
        .gpio_out     (gpio_out),
        .gpio_oe      (gpio_oe),
        .gpio_in_func (gpio_in_func),
        .busy         (busy),
        .sel_err      (sel_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Reference model: per pin, the function in use, the target
    // function and the cycle whose closing edge ends the drain.
    logic [W-1:0] m_out = '0;
    logic [W-1:0] m_oe = '0;
    logic [W-1:0] m_drn = '0;
    logic         m_err = 1'b0;
    logic [W-1:0] m_s1 = '0;
    logic [W-1:0] m_s2 = '0;
    int           m_act [W];
    int           m_tgt [W];
    int           m_end [W];
    int           cyc = 0;

    initial begin
        for (int i = 0; i < W; i++) begin
            m_act[i] = 0;
            m_tgt[i] = 0;
            m_end[i] = 0;
        end
    end

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_out = '0;
            m_oe  = '0;
            m_drn = '0;
            m_err = 1'b0;
            m_s1  = '0;
            m_s2  = '0;
            for (int i = 0; i < W; i++) begin
                m_act[i] = 0;
                m_tgt[i] = 0;
            end
        end else begin
            for (int i = 0; i < W; i++) begin
                int r;
                r = int'(sel[i*SW +: SW]);
                if (sel_wr && r >= NF) m_err = 1'b1;
                if (sel_wr && r < NF) begin
                    if (!m_drn[i] && r != m_act[i]) begin
                        m_drn[i] = 1'b1;
                        m_tgt[i] = r;
                        m_end[i] = cyc + G;
                    end else if (m_drn[i] && r != m_tgt[i]) begin
                        m_tgt[i] = r;
                        m_end[i] = cyc + G;
                    end
                end
                if (m_drn[i] && m_end[i] == cyc) begin
                    m_drn[i] = 1'b0;
                    m_act[i] = m_tgt[i];
                end
                if (m_drn[i]) begin
                    m_oe[i] = 1'b0;
                end else begin
                    m_out[i] = func_out[m_act[i]*W+i];
                    m_oe[i]  = func_oe[m_act[i]*W+i];
                end
            end
            m_s2 = m_s1;
            m_s1 = gpio_in;
            cyc++;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        logic [W-1:0] exp_in;
`ifdef GPIO_FUNC_SWITCH_SYNC_EN
        exp_in = m_s2;
`else
        exp_in = gpio_in;
`endif
        chk("m_gpio_out", gpio_out, m_out);
        chk("m_gpio_oe", gpio_oe, m_oe);
        chk("m_busy", busy, m_drn);
        chk("m_sel_err", W'(sel_err), W'(m_err));
        chk("m_gpio_in_func", gpio_in_func, exp_in);
    end

    task automatic nx();
        @(negedge clk);
    endtask

    task automatic set_pin(input int p, input int v);
        sel[p*SW +: SW] = SW'(v);
    endtask

    task automatic idle(input int n);
        repeat (n) nx();
        #1;
    endtask

    initial begin
        func_out = {16'h5A5A, 16'h3333, 16'h0F0F, 16'h00FF};
        func_oe  = {16'hF0F5, 16'hAAAA, 16'h0F0F, 16'hFFFF};

        // reset state
        nx();
        nx();
        chk("rst_out", gpio_out, 16'h0000);
        chk("rst_oe", gpio_oe, 16'h0000);
        chk("rst_busy", busy, 16'h0000);
        chk("rst_err", W'(sel_err), 16'h0000);
        #1 resetn = 1'b1;
        nx();
        chk("rel_out", gpio_out, 16'h00FF);
        chk("rel_oe", gpio_oe, 16'hFFFF);
        chk("rel_busy", busy, 16'h0000);
        #1 gpio_in = 16'hA5C3;
        idle(2);

        // pin 3: function 0 -> 2
        set_pin(3, 2);
        sel_wr = 1'b1;
        for (int k = 1; k <= G; k++) begin
            nx();
            chk("p3_busy", busy, 16'h0008);
            chk("p3_oe", gpio_oe, 16'hFFF7);
            chk("p3_hold", gpio_out, 16'h00FF);
            #1 sel_wr = 1'b0;
        end
        nx();
        chk("p3_out", gpio_out, 16'h00F7);
        chk("p3_oe_new", gpio_oe, 16'hFFFF);
        chk("p3_idle", busy, 16'h0000);
        idle(2);

        // pin 5: 0 -> 1, retargeted to 3 two cycles later
        set_pin(5, 1);
        sel_wr = 1'b1;
        nx();
        #1 sel_wr = 1'b0;
        gpio_in = 16'h0F31;
        nx();
        #1 set_pin(5, 3);
        sel_wr = 1'b1;
        for (int k = 3; k <= 6; k++) begin
            nx();
            chk("p5_busy", busy, 16'h0020);
            chk("p5_oe", gpio_oe, 16'hFFDF);
            #1 sel_wr = 1'b0;
        end
        nx();
        chk("p5_out", gpio_out, 16'h00D7);
        chk("p5_oe_new", gpio_oe, 16'hFFFF);
        chk("p5_idle", busy, 16'h0000);
        #1;

        // pin 0 to function 3 first
        set_pin(0, 3);
        sel_wr = 1'b1;
        nx();
        #1 sel_wr = 1'b0;
        idle(G + 1);
        chk("p0_out", gpio_out, 16'h00D6);

        // pin 0 rewritten with its own select, pin 1 switches
        set_pin(1, 3);
        sel_wr = 1'b1;
        for (int k = 1; k <= G; k++) begin
            nx();
            chk("p01_busy", busy, 16'h0002);
            chk("p01_oe", gpio_oe, 16'hFFFD);
            #1 sel_wr = 1'b0;
        end
        nx();
        chk("p1_oe_new", gpio_oe, 16'hFFFD);
        chk("p1_idle", busy, 16'h0000);
        #1;

        // out-of-range select on pin 2, valid switch on pin 6
        set_pin(2, 4);
        set_pin(6, 2);
        sel_wr = 1'b1;
        nx();
        chk("err_set", W'(sel_err), 16'h0001);
        chk("err_busy", busy, 16'h0040);
        chk("err_oe", gpio_oe, 16'hFFBD);
        #1 sel_wr = 1'b0;
        set_pin(2, 0);
        gpio_in = 16'h7E81;
        repeat (G) nx();
        chk("p6_out", gpio_out, 16'h0096);
        chk("p6_oe", gpio_oe, 16'hFFBD);
        #1 set_pin(7, 7);
        sel_wr = 1'b1;
        nx();
        chk("err7_busy", busy, 16'h0000);
        #1 sel_wr = 1'b0;
        set_pin(7, 0);
        idle(3);
        chk("err_sticky", W'(sel_err), 16'h0001);

        // reset in the middle of a drain
        set_pin(4, 1);
        sel_wr = 1'b1;
        nx();
        #1 sel_wr = 1'b0;
        nx();
        #1 resetn = 1'b0;
        #1;
        chk("mid_rst_out", gpio_out, 16'h0000);
        chk("mid_rst_oe", gpio_oe, 16'h0000);
        chk("mid_rst_busy", busy, 16'h0000);
        chk("mid_rst_err", W'(sel_err), 16'h0000);
        sel = '0;
        nx();
        #1 resetn = 1'b1;
        nx();
        chk("post_rst_out", gpio_out, 16'h00FF);
        chk("post_rst_oe", gpio_oe, 16'hFFFF);
        chk("post_rst_busy", busy, 16'h0000);
        idle(1);

        // input return path latency
        gpio_in = 16'h0000;
        idle(3);
        gpio_in = 16'h8001;
`ifdef GPIO_FUNC_SWITCH_SYNC_EN
        #1 chk("in_lat0", gpio_in_func, 16'h0000);
        nx();
        chk("in_lat1", gpio_in_func, 16'h0000);
        nx();
        chk("in_lat2", gpio_in_func, 16'h8001);
`else
        #1 chk("in_lat0", gpio_in_func, 16'h8001);
        nx();
        chk("in_lat1", gpio_in_func, 16'h8001);
`endif
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_miss);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
